// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon absorb engine: mode codes, rates,
// round constant and padding helpers, and the 320-bit state type.
package ascon_pkg;

   localparam int STATE_W    = 320;
   localparam int MAX_ROUNDS = 12;

   typedef logic [STATE_W-1:0] ascon_state_t;

   localparam logic [1:0] AEAD128 = 2'b00;
   localparam logic [1:0] HASH256 = 2'b01;
   localparam logic [1:0] XOF128  = 2'b10;
   localparam logic [1:0] CXOF128 = 2'b11;

   localparam logic [4:0] RATE_AEAD = 5'd16;
   localparam logic [4:0] RATE_HASH = 5'd8;

   // Block rate in bytes for a mode
   function automatic logic [4:0] rate_bytes(input logic [1:0] m);
      return (m == AEAD128) ? RATE_AEAD : RATE_HASH;
   endfunction

   // Round constant for round index i (counted so the last round is 11)
   function automatic logic [7:0] rc(input logic [3:0] i);
      return {4'hF - i, i};
   endfunction

   // Keep the low n bytes of d and place the 0x01 pad byte just above them;
   // n = 8 returns the full word with no pad byte
   function automatic logic [63:0] pad_word(input logic [63:0] d, input logic [3:0] n);
      logic [63:0] w;
      w = '0;
      for (int b = 0; b < 8; b++) begin
         if (4'(b) < n)
            w[8*b +: 8] = d[8*b +: 8];
         else if (4'(b) == n)
            w[8*b +: 8] = 8'h01;
      end
      return w;
   endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition into x2, the 5-bit
// bitsliced S-box, and the per-word linear diffusion layer.
module ascon_round
   import ascon_pkg::*;
(
   input  logic [STATE_W-1:0] state_in,
   input  logic [3:0]         round_idx,
   output logic [STATE_W-1:0] state_out
);

   function automatic logic [63:0] ror(input logic [63:0] x, input int r);
      return (x >> r) | (x << (64 - r));
   endfunction

   logic [63:0] a0, a1, a2, a3, a4;
   logic [63:0] p0, p2, p4;
   logic [63:0] q0, q1, q2, q3, q4;
   logic [63:0] s0, s1, s2, s3, s4;

   assign a0 = state_in[319:256];
   assign a1 = state_in[255:192];
   assign a2 = state_in[191:128] ^ {56'h0, rc(round_idx)};
   assign a3 = state_in[127:64];
   assign a4 = state_in[63:0];

   // S-box input mixing
   assign p0 = a0 ^ a4;
   assign p2 = a2 ^ a1;
   assign p4 = a4 ^ a3;

   // Chi-like nonlinear core
   assign q0 = p0 ^ (~a1 & p2);
   assign q1 = a1 ^ (~p2 & a3);
   assign q2 = p2 ^ (~a3 & p4);
   assign q3 = a3 ^ (~p4 & p0);
   assign q4 = p4 ^ (~p0 & a1);

   // S-box output mixing
   assign s0 = q0 ^ q4;
   assign s1 = q1 ^ q0;
   assign s2 = ~q2;
   assign s3 = q3 ^ q2;
   assign s4 = q4;

   assign state_out = {s0 ^ ror(s0, 19) ^ ror(s0, 28),
                       s1 ^ ror(s1, 61) ^ ror(s1, 39),
                       s2 ^ ror(s2,  1) ^ ror(s2,  6),
                       s3 ^ ror(s3, 10) ^ ror(s3, 17),
                       s4 ^ ror(s4,  7) ^ ror(s4, 41)};

endmodule

// File: rtl/ascon_absorb_engine.sv
// Streaming absorb engine for Ascon AEAD128 / Hash256 / XOF128 / CXOF128.
// Pads and XORs rate-sized blocks into the state, permutes with UNROLL
// rounds per clock and hands the final state to the squeeze/encrypt stage.
// Optional: define ASCON_ABSORB_DOMSEP_EN to fold the AEAD domain-separation
// bit (x4 MSB) into the final permutation output.
module ascon_absorb_engine
   import ascon_pkg::*;
#(
   parameter int UNROLL      = 1,
   parameter int AEAD_ROUNDS = 8,
   parameter int HASH_ROUNDS = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [STATE_W-1:0] state_i,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [127:0]       in_data,
   input  logic [4:0]         in_bytes,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] state_o,
   output logic               busy,
   output logic               err
);

   localparam int CNT_W = $clog2(HASH_ROUNDS + 1);
   localparam logic [CNT_W-1:0] AEAD_START = CNT_W'(MAX_ROUNDS - AEAD_ROUNDS);
   localparam logic [CNT_W-1:0] HASH_START = CNT_W'(MAX_ROUNDS - HASH_ROUNDS);
   localparam logic [CNT_W-1:0] LAST_STEP  = CNT_W'(MAX_ROUNDS - UNROLL);
   localparam logic [CNT_W-1:0] STEP       = CNT_W'(UNROLL);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_PERM = 3'd2;
   localparam logic [2:0] S_PAD  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

`ifdef ASCON_ABSORB_DOMSEP_EN
   localparam logic [63:0] DOMSEP_X4 = 64'h8000_0000_0000_0000;
`else
   localparam logic [63:0] DOMSEP_X4 = 64'h0;
`endif

   localparam ascon_state_t PAD_ONLY = {63'h0, 1'b1, 256'h0};

   logic [2:0]       fsm_reg, fsm_next;
   ascon_state_t     st_reg, st_next;
   ascon_state_t     out_reg, out_next;
   logic [1:0]       mode_reg, mode_next;
   logic [CNT_W-1:0] round_reg, round_next;
   logic             last_reg, last_next;
   logic             pad_reg, pad_next;
   logic             err_reg, err_next;

   logic             is_aead;
   logic [4:0]       rate;
   logic             beat_full, beat_illegal;
   logic [CNT_W-1:0] start_idx;
   logic [63:0]      blk_x0, blk_x1;
   ascon_state_t     absorbed, perm_out, perm_final;
   ascon_state_t     chain [UNROLL+1];

   assign is_aead      = (mode_reg == AEAD128);
   assign rate         = rate_bytes(mode_reg);
   assign start_idx    = is_aead ? AEAD_START : HASH_START;
   assign beat_full    = (in_bytes == rate);
   assign beat_illegal = (in_bytes > rate) || (!in_last && !beat_full);

   // Padded block: x0 takes the first eight bytes, x1 the rest (AEAD only)
   assign blk_x0   = pad_word(in_data[127:64], (in_bytes >= 5'd8) ? 4'd8 : in_bytes[3:0]);
   assign blk_x1   = (is_aead && in_bytes >= 5'd8) ? pad_word(in_data[63:0], 4'(in_bytes - 5'd8)) : 64'h0;
   assign absorbed = st_reg ^ {blk_x0, blk_x1, 192'h0};

   // UNROLL rounds chained combinationally, consecutive round indices
   assign chain[0] = st_reg;
   generate
      for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
         ascon_round u_round (
            .state_in  (chain[gi]),
            .round_idx (4'(round_reg) + 4'(gi)),
            .state_out (chain[gi+1])
         );
      end
   endgenerate
   assign perm_out   = chain[UNROLL];
   assign perm_final = perm_out ^ {256'h0, (is_aead ? DOMSEP_X4 : 64'h0)};

   assign in_ready  = (fsm_reg == S_WAIT);
   assign out_valid = (fsm_reg == S_DONE);
   assign busy      = (fsm_reg != S_IDLE);
   assign err       = err_reg;
   assign state_o   = out_reg;

   // Next-state logic: FSM, round counter, padding flags and state update
   always_comb begin
      fsm_next   = fsm_reg;
      st_next    = st_reg;
      out_next   = out_reg;
      mode_next  = mode_reg;
      round_next = round_reg;
      last_next  = last_reg;
      pad_next   = pad_reg;
      err_next   = 1'b0;
      case (fsm_reg)
         S_IDLE: begin
            if (start) begin
               fsm_next  = S_WAIT;
               st_next   = state_i;
               mode_next = mode;
            end
         end
         S_WAIT: begin
            if (in_valid) begin
               if (beat_illegal) begin
                  err_next = 1'b1;
               end else begin
                  st_next    = absorbed;
                  last_next  = in_last;
                  pad_next   = in_last && beat_full;
                  round_next = start_idx;
                  if (in_last && !beat_full && !is_aead) begin
                     // Hash-family final partial block is not permuted
                     fsm_next = S_DONE;
                     out_next = absorbed;
                  end else begin
                     fsm_next = S_PERM;
                  end
               end
            end
         end
         S_PERM: begin
            st_next    = perm_out;
            round_next = round_reg + STEP;
            if (round_reg == LAST_STEP) begin
               if (!last_reg) begin
                  fsm_next = S_WAIT;
               end else if (pad_reg) begin
                  fsm_next = S_PAD;
               end else begin
                  fsm_next = S_DONE;
                  st_next  = perm_final;
                  out_next = perm_final;
               end
            end
         end
         S_PAD: begin
            st_next    = st_reg ^ PAD_ONLY;
            pad_next   = 1'b0;
            round_next = start_idx;
            if (is_aead) begin
               fsm_next = S_PERM;
            end else begin
               fsm_next = S_DONE;
               out_next = st_reg ^ PAD_ONLY;
            end
         end
         S_DONE: begin
            if (start) begin
               fsm_next  = S_WAIT;
               st_next   = state_i;
               mode_next = mode;
            end else if (out_ready) begin
               fsm_next = S_IDLE;
            end
         end
         default: fsm_next = S_IDLE;
      endcase
   end

   // State registers with asynchronous abort
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_reg   <= S_IDLE;
         st_reg    <= '0;
         out_reg   <= '0;
         mode_reg  <= AEAD128;
         round_reg <= '0;
         last_reg  <= 1'b0;
         pad_reg   <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         fsm_reg   <= fsm_next;
         st_reg    <= st_next;
         out_reg   <= out_next;
         mode_reg  <= mode_next;
         round_reg <= round_next;
         last_reg  <= last_next;
         pad_reg   <= pad_next;
         err_reg   <= err_next;
      end
   end

endmodule

// File: tb/tb_ascon_absorb_engine.sv
// Self-checking bench for ascon_absorb_engine: a reference absorb model
// feeds a queue of expected final states, compared when out_valid rises.
module tb_ascon_absorb_engine;

   localparam int UNROLL = 1;
   localparam int R_AEAD = 8 / UNROLL;
   localparam int R_HASH = 12 / UNROLL;

   localparam logic [1:0] M_AEAD = 2'b00;
   localparam logic [1:0] M_HASH = 2'b01;
   localparam logic [1:0] M_XOF  = 2'b10;
   localparam logic [1:0] M_CXOF = 2'b11;

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
   localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
   localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

   logic         clk = 0;
   logic         rst_n = 0;
   logic         start = 0;
   logic [1:0]   mode = 0;
   logic [319:0] state_i = '0;
   logic         in_valid = 0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic [4:0]   in_bytes = 0;
   logic         in_last = 0;
   logic         out_valid;
   logic         out_ready = 0;
   logic [319:0] state_o;
   logic         busy;
   logic         err;

   int checks = 0;
   int errors = 0;
   logic [319:0] exp_q [$];
   logic [319:0] model_st;
   logic [1:0]   model_mode;

   ascon_absorb_engine #(.UNROLL(UNROLL), .AEAD_ROUNDS(8), .HASH_ROUNDS(12)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .state_i(state_i),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_bytes(in_bytes), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .state_o(state_o), .busy(busy), .err(err));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [63:0] rotr(input logic [63:0] x, input int r);
      logic [127:0] t;
      t = {x, x} >> r;
      return t[63:0];
   endfunction

   function automatic logic [319:0] ref_round(input logic [319:0] s, input int r);
      logic [63:0] x [5];
      logic [63:0] y [5];
      logic [4:0] col, o;
      logic [319:0] res;
      for (int k = 0; k < 5; k++) begin
         x[k] = s[319-64*k -: 64];
         y[k] = '0;
      end
      x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
      for (int j = 0; j < 64; j++) begin
         col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
         o = SBOX[col];
         for (int k = 0; k < 5; k++) y[k][j] = o[4-k];
      end
      for (int k = 0; k < 5; k++)
         res[319-64*k -: 64] = y[k] ^ rotr(y[k], ROT_A[k]) ^ rotr(y[k], ROT_B[k]);
      return res;
   endfunction

   function automatic logic [319:0] ref_perm(input logic [319:0] s, input int nr);
      logic [319:0] t = s;
      for (int r = 12 - nr; r < 12; r++) t = ref_round(t, r);
      return t;
   endfunction

   function automatic logic [319:0] ref_final(input logic [319:0] s);
      logic [319:0] t = ref_perm(s, 8);
`ifdef ASCON_ABSORB_DOMSEP_EN
      t[63] = ~t[63];
`endif
      return t;
   endfunction

   function automatic logic [319:0] model_block(input logic [319:0] st, input logic aead,
                                                input logic [127:0] d, input int n, input logic last);
      logic [319:0] s = st;
      int rate = aead ? 16 : 8;
      int nr   = aead ? 8 : 12;
      int src, dst;
      for (int k = 0; k < 16; k++) begin
         if (k < n) begin
            src = (k < 8) ? 64 + 8*k : 8*(k-8);
            dst = (k < 8) ? 256 + 8*k : 192 + 8*(k-8);
            s[dst +: 8] = s[dst +: 8] ^ d[src +: 8];
         end
      end
      if (n < rate) begin
         dst = (n < 8) ? 256 + 8*n : 192 + 8*(n-8);
         s[dst] = ~s[dst];
      end
      if (!last) s = ref_perm(s, nr);
      else if (n < rate) begin
         if (aead) s = ref_final(s);
      end else begin
         s = ref_perm(s, nr);
         s[256] = ~s[256];
         if (aead) s = ref_final(s);
      end
      return s;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [319:0] rand320();
      return {$urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- stimulus tasks ----------------
   task automatic do_start(input logic [1:0] m, input logic [319:0] st);
      start = 1; mode = m; state_i = st;
      @(negedge clk);
      start = 0;
      model_st = st; model_mode = m;
   endtask

   task automatic send_block(input logic [127:0] d, input int n, input logic last);
      int guard = 0;
      int rate = (model_mode == M_AEAD) ? 16 : 8;
      in_data = d; in_bytes = 5'(n); in_last = last; in_valid = 1;
      while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL handshake_timeout: in_ready=%b required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 0;
      if (n <= rate && (last || n == rate)) begin
         model_st = model_block(model_st, model_mode == M_AEAD, d, n, last);
         if (last) exp_q.push_back(model_st);
      end
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 0;
      while (!in_ready && cyc < 200) begin @(negedge clk); cyc++; end
   endtask

   task automatic wait_out(output int cyc, output bit saw_ready);
      cyc = 0; saw_ready = 0;
      while (!out_valid && cyc < 200) begin
         if (in_ready) saw_ready = 1;
         @(negedge clk); cyc++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
      end
   endtask

   task automatic take_output(input string name);
      logic [319:0] held = state_o;
      logic [319:0] exp;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || state_o !== held) begin
         errors++;
         $display("FAIL %s_hold: out_valid=%b state_o=%h required 1 and %h", name, out_valid, state_o, held);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s_scoreboard: got an output with 0 expected entries, required 1", name);
      end else begin
         exp = exp_q.pop_front();
         if (state_o !== exp) begin
            errors++;
            $display("FAIL %s_state: got %h required %h", name, state_o, exp);
         end else
            $display("%s: state_o=%h", name, state_o);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL %s_release: out_valid,busy=%b required 00", name, {out_valid, busy});
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy, err} !== 4'b0 || state_o !== '0) begin
         errors++;
         $display("FAIL reset_outputs: flags=%b state_o=%h required all 0", {in_ready, out_valid, busy, err}, state_o);
      end
      rst_n = 1;
      @(negedge clk);
      checks++;
      if ({in_ready, busy} !== 2'b00) begin
         errors++;
         $display("FAIL reset_idle: in_ready,busy=%b required 00", {in_ready, busy});
      end
   endtask

   task automatic test_aead_full();
      logic [127:0] d;
      int cyc; bit saw;
      for (int k = 0; k < 8; k++) begin
         d[64 + 8*k +: 8] = 8'(k);
         d[8*k +: 8]      = 8'(k + 8);
      end
      do_start(M_AEAD, '0);
      checks++;
      if ({in_ready, busy} !== 2'b11) begin
         errors++;
         $display("FAIL aead_full_wait: in_ready,busy=%b required 11", {in_ready, busy});
      end
      send_block(d, 16, 1);
      wait_out(cyc, saw);
      checks++;
      if (cyc != 2*R_AEAD + 1 || saw) begin
         errors++;
         $display("FAIL aead_full_latency: cycles=%0d ready_seen=%0d required %0d and 0", cyc, saw, 2*R_AEAD + 1);
      end
      take_output("aead_full");
   endtask

   task automatic test_hash_partial();
      logic [319:0] st = {64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444,
                          64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};
      int cyc; bit saw;
      do_start(M_HASH, st);
      send_block({64'h0000_0000_00AA_BBCC, 64'hFFFF_FFFF_FFFF_FFFF}, 3, 1);
      wait_out(cyc, saw);
      checks++;
      if (cyc != 0) begin
         errors++;
         $display("FAIL hash_partial_latency: cycles=%0d required 0", cyc);
      end
      checks++;
      if (state_o !== {st[319:256] ^ 64'h0000_0000_01AA_BBCC, st[255:0]}) begin
         errors++;
         $display("FAIL hash_partial_direct: got %h required %h", state_o, {st[319:256] ^ 64'h0000_0000_01AA_BBCC, st[255:0]});
      end
      take_output("hash_partial");
   endtask

   task automatic test_multi_block();
      int cyc; bit saw;
      // XOF: two full blocks then a 5-byte tail; start during PERM is ignored
      do_start(M_XOF, rand320());
      send_block(rand128(), 8, 0);
      wait_ready(cyc);
      checks++;
      if (cyc != R_HASH) begin
         errors++;
         $display("FAIL xof_block_latency: cycles=%0d required %0d", cyc, R_HASH);
      end
      send_block(rand128(), 8, 0);
      start = 1; state_i = rand320(); mode = M_AEAD;
      @(negedge clk);
      start = 0;
      wait_ready(cyc);
      checks++;
      if (cyc + 1 != R_HASH) begin
         errors++;
         $display("FAIL xof_start_ignored_latency: cycles=%0d required %0d", cyc + 1, R_HASH);
      end
      send_block(rand128(), 5, 1);
      wait_out(cyc, saw);
      take_output("xof_multi");
      // Hash256 full final block: permute, then pad-only block, no permute
      do_start(M_HASH, rand320());
      send_block(rand128(), 8, 1);
      wait_out(cyc, saw);
      checks++;
      if (cyc != R_HASH + 1) begin
         errors++;
         $display("FAIL hash_full_latency: cycles=%0d required %0d", cyc, R_HASH + 1);
      end
      take_output("hash_full");
      // AEAD: full block then a 9-byte tail (pad lands in x1)
      do_start(M_AEAD, rand320());
      send_block(rand128(), 16, 0);
      wait_ready(cyc);
      checks++;
      if (cyc != R_AEAD) begin
         errors++;
         $display("FAIL aead_block_latency: cycles=%0d required %0d", cyc, R_AEAD);
      end
      send_block(rand128(), 9, 1);
      wait_out(cyc, saw);
      checks++;
      if (cyc != R_AEAD) begin
         errors++;
         $display("FAIL aead_tail_latency: cycles=%0d required %0d", cyc, R_AEAD);
      end
      take_output("aead_tail9");
      // CXOF empty final block
      do_start(M_CXOF, rand320());
      send_block(rand128(), 0, 1);
      wait_out(cyc, saw);
      take_output("cxof_empty");
   endtask

   task automatic test_illegal();
      logic [319:0] saved;
      int cyc; bit saw;
      for (int t = 0; t < 2; t++) begin
         do_start(t == 0 ? M_AEAD : M_XOF, rand320());
         saved = state_o;
         if (t == 0) send_block(rand128(), 17, 1);
         else        send_block(rand128(), 5, 0);
         checks++;
         if ({err, in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL illegal%0d_err: err,in_ready=%b required 11", t, {err, in_ready});
         end
         @(negedge clk);
         checks++;
         if (err !== 1'b0 || in_ready !== 1'b1 || state_o !== saved) begin
            errors++;
            $display("FAIL illegal%0d_after: err=%b in_ready=%b state_o=%h required 0,1,%h", t, err, in_ready, state_o, saved);
         end
         send_block(rand128(), t == 0 ? 4 : 8, 1);
         wait_out(cyc, saw);
         take_output(t == 0 ? "illegal_aead_recover" : "illegal_xof_recover");
      end
   endtask

   task automatic test_reset_mid_perm();
      do_start(M_HASH, rand320());
      send_block(rand128(), 8, 0);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      checks++;
      if ({in_ready, out_valid, busy, err} !== 4'b0 || state_o !== '0) begin
         errors++;
         $display("FAIL async_reset: flags=%b state_o=%h required all 0", {in_ready, out_valid, busy, err}, state_o);
      end
      @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL reset_stays_idle: out_valid,busy=%b required 00", {out_valid, busy});
      end
   endtask

   task automatic test_aead_empty();
      int cyc; bit saw;
      do_start(M_AEAD, rand320());
      send_block(rand128(), 0, 1);
      wait_out(cyc, saw);
      checks++;
      if (cyc != R_AEAD) begin
         errors++;
         $display("FAIL aead_empty_latency: cycles=%0d required %0d", cyc, R_AEAD);
      end
      take_output("aead_empty");
   endtask

   task automatic test_restart_done();
      logic [319:0] st2 = rand320();
      int cyc; bit saw;
      do_start(M_HASH, rand320());
      send_block(rand128(), 2, 1);
      wait_out(cyc, saw);
      start = 1; out_ready = 1; mode = M_XOF; state_i = st2;
      @(negedge clk);
      start = 0; out_ready = 0;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL restart_in_done: out_valid,in_ready=%b required 01", {out_valid, in_ready});
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      model_st = st2; model_mode = M_XOF;
      send_block(rand128(), 8, 1);
      wait_out(cyc, saw);
      take_output("restart");
   endtask

   initial begin
      test_reset();
      test_aead_full();
      test_hash_partial();
      test_multi_block();
      test_illegal();
      test_reset_mid_perm();
      test_aead_empty();
      test_restart_done();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
